// File: rtl/rf_pkg.sv
// Shared register-file definitions: default sizes and the register index type
// used by decode, writeback and the register file itself.
package rf_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_idx_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits marking registers with an outstanding producer.
// Priority per bit: claim sets, then flush clears, then a write clears.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             claim_en,
  input  logic [AW-1:0]    claim_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             flush,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < NREGS; i++) begin
      if (claim_en && claim_addr == AW'(i)) busy_nxt[i] = 1'b1;
      else if (flush)                       busy_nxt[i] = 1'b0;
      else if (wr_en && wr_addr == AW'(i)) busy_nxt[i] = 1'b0;
    end
    // x0 never has a producer when it is hardwired
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

endmodule

// File: rtl/rf_multi.sv
// Multi-port integer register file with hardwired x0, same-cycle write bypass
// and a busy scoreboard for decode hazard detection.
module rf_multi
  import rf_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              claim_en,
  input  logic [AW-1:0]     claim_addr,
  input  logic              flush
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             wr_hit;
  logic [AW-1:0]    ra;

  assign wr_hit = wr_en && !(ZERO_REG != 0 && wr_addr == '0);

  rf_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .flush      (flush),
    .busy       (busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports: x0 mask wins, then the in-flight write, then stored state
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int p = 0; p < NRD; p++) begin
      ra = rd_addr[p*AW +: AW];
      if (ZERO_REG != 0 && ra == '0) begin
        rd_data[p*XLEN +: XLEN] = '0;
        rd_busy[p]              = 1'b0;
      end else if (BYPASS != 0 && wr_en && wr_addr == ra) begin
        rd_data[p*XLEN +: XLEN] = wr_data;
        rd_busy[p]              = 1'b0;
      end else begin
        rd_data[p*XLEN +: XLEN] = regs[ra];
        rd_busy[p]              = busy[ra];
      end
    end
  end

endmodule

// File: tb/tb_rf_multi.sv
// Bench for rf_multi: default config, a no-bypass copy sharing its stimulus,
// and a 16x64 three-port instance.
module tb_rf_multi;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [63:0] rd_data_nb;
  logic [1:0]  rd_busy_nb;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        claim_en;
  logic [4:0]  claim_addr;
  logic        flush;

  logic [11:0]  p_rd_addr;
  logic [191:0] p_rd_data;
  logic [2:0]   p_rd_busy;
  logic         p_wr_en;
  logic [3:0]   p_wr_addr;
  logic [63:0]  p_wr_data;
  logic         p_claim_en;
  logic [3:0]   p_claim_addr;
  logic         p_flush;

  typedef struct {
    string       name;
    int          dut;
    int          port;
    logic [63:0] data;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  rf_multi u_dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .flush(flush)
  );

  rf_multi #(.BYPASS(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .flush(flush)
  );

  rf_multi #(.XLEN(64), .NREGS(16), .NRD(3)) u_dut_p (
    .clk(clk), .rst_n(rst_n), .rd_addr(p_rd_addr), .rd_data(p_rd_data), .rd_busy(p_rd_busy),
    .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
    .claim_en(p_claim_en), .claim_addr(p_claim_addr), .flush(p_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [64:0] act(input int dut, input int port);
    case (dut)
      0:       act = {rd_busy[port], 32'h0, rd_data[port*32 +: 32]};
      1:       act = {rd_busy_nb[port], 32'h0, rd_data_nb[port*32 +: 32]};
      default: act = {p_rd_busy[port], p_rd_data[port*64 +: 64]};
    endcase
  endfunction

  task automatic push(input string name, input int dut, input int port,
                      input logic [63:0] data, input logic busy);
    exp_t e;
    e.name = name; e.dut = dut; e.port = port; e.data = data; e.busy = busy;
    exp_q.push_back(e);
  endtask

  task automatic clr_strobes();
    wr_en = 1'b0; claim_en = 1'b0; flush = 1'b0;
    p_wr_en = 1'b0; p_claim_en = 1'b0; p_flush = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [64:0] a;
    for (int ph = 0; ph < 3; ph++) begin
      case (ph)
        0: begin
          @(negedge clk);
          rd_addr = {5'd5, 5'd9};
          p_rd_addr = {4'd3, 4'd2, 4'd1};
          push("reset_p0", 0, 0, 64'h0, 1'b0);
          push("reset_p1", 0, 1, 64'h0, 1'b0);
          push("reset_nb", 1, 0, 64'h0, 1'b0);
          for (int p = 0; p < 3; p++) push("reset_param", 2, p, 64'h0, 1'b0);
        end
        1: begin
          @(negedge clk);
          wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
          claim_en = 1'b1; claim_addr = 5'd5;
          @(negedge clk);
          clr_strobes();
          push("pre_reset_x5", 0, 1, 64'hDEADBEEF, 1'b1);
          push("pre_reset_x5_nb", 1, 1, 64'hDEADBEEF, 1'b1);
        end
        default: begin
          #1 rst_n = 1'b0;
          push("async_reset_x5", 0, 1, 64'h0, 1'b0);
          push("async_reset_x9", 0, 0, 64'h0, 1'b0);
          push("async_reset_x5_nb", 1, 1, 64'h0, 1'b0);
        end
      endcase
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = act(e.dut, e.port);
        n_checks++;
        if (a[63:0] !== e.data || a[64] !== e.busy) begin
          n_errors++;
          $display("FAIL %s dut%0d port%0d: got data=%h busy=%b, expected data=%h busy=%b",
                   e.name, e.dut, e.port, a[63:0], a[64], e.data, e.busy);
        end
      end
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_zero_reg();
    exp_t e;
    logic [64:0] a;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      clr_strobes();
      if (c == 0) begin
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        claim_en = 1'b1; claim_addr = 5'd0;
        rd_addr = {5'd0, 5'd0};
      end
      push("zero_p0", 0, 0, 64'h0, 1'b0);
      push("zero_p1", 0, 1, 64'h0, 1'b0);
      push("zero_nb", 1, 0, 64'h0, 1'b0);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = act(e.dut, e.port);
        n_checks++;
        if (a[63:0] !== e.data || a[64] !== e.busy) begin
          n_errors++;
          $display("FAIL %s cyc%0d dut%0d port%0d: got data=%h busy=%b, expected data=%h busy=%b",
                   e.name, c, e.dut, e.port, a[63:0], a[64], e.data, e.busy);
        end
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    logic [64:0] a;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      clr_strobes();
      rd_addr = {5'd7, 5'd7};
      if (c == 0) begin
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        push("bypass_p0", 0, 0, 64'hA5A5A5A5, 1'b0);
        push("bypass_p1", 0, 1, 64'hA5A5A5A5, 1'b0);
        push("nobypass_old", 1, 0, 64'h0, 1'b0);
      end else begin
        push("bypass_state", 0, 0, 64'hA5A5A5A5, 1'b0);
        push("nobypass_new", 1, 0, 64'hA5A5A5A5, 1'b0);
      end
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = act(e.dut, e.port);
        n_checks++;
        if (a[63:0] !== e.data || a[64] !== e.busy) begin
          n_errors++;
          $display("FAIL %s dut%0d port%0d: got data=%h busy=%b, expected data=%h busy=%b",
                   e.name, e.dut, e.port, a[63:0], a[64], e.data, e.busy);
        end
      end
    end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    logic [64:0] a;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      clr_strobes();
      rd_addr = {5'd3, 5'd3};
      case (c)
        0: begin
          claim_en = 1'b1; claim_addr = 5'd3;
          push("claim_same_cyc", 0, 0, 64'h0, 1'b0);
          push("claim_same_cyc_nb", 1, 0, 64'h0, 1'b0);
        end
        1, 2: begin
          push("claimed_p0", 0, 0, 64'h0, 1'b1);
          push("claimed_p1", 0, 1, 64'h0, 1'b1);
          push("claimed_nb", 1, 0, 64'h0, 1'b1);
        end
        3: begin
          wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h10;
          push("wb_bypass_clear", 0, 0, 64'h10, 1'b0);
          push("wb_nobypass", 1, 0, 64'h0, 1'b1);
        end
        default: begin
          push("wb_state_clear", 0, 0, 64'h10, 1'b0);
          push("wb_state_clear_nb", 1, 0, 64'h10, 1'b0);
        end
      endcase
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = act(e.dut, e.port);
        n_checks++;
        if (a[63:0] !== e.data || a[64] !== e.busy) begin
          n_errors++;
          $display("FAIL %s cyc%0d dut%0d port%0d: got data=%h busy=%b, expected data=%h busy=%b",
                   e.name, c, e.dut, e.port, a[63:0], a[64], e.data, e.busy);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    logic [64:0] a;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      clr_strobes();
      case (c)
        0: begin
          claim_en = 1'b1; claim_addr = 5'd9;
          wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
          rd_addr = {5'd4, 5'd9};
          push("wr_claim_bypass", 0, 0, 64'h55, 1'b0);
          push("wr_claim_nb", 1, 0, 64'h0, 1'b0);
        end
        1: begin
          claim_en = 1'b1; claim_addr = 5'd2;
          rd_addr = {5'd2, 5'd9};
          push("wr_claim_next", 0, 0, 64'h55, 1'b1);
          push("wr_claim_next_nb", 1, 0, 64'h55, 1'b1);
          push("x2_before_claim", 0, 1, 64'h0, 1'b0);
        end
        2: begin
          claim_en = 1'b1; claim_addr = 5'd4;
          rd_addr = {5'd4, 5'd2};
          push("x2_busy", 0, 0, 64'h0, 1'b1);
          push("x4_before_claim", 0, 1, 64'h0, 1'b0);
        end
        3: begin
          flush = 1'b1; claim_en = 1'b1; claim_addr = 5'd4;
          rd_addr = {5'd4, 5'd2};
          push("pre_flush_x2", 0, 0, 64'h0, 1'b1);
          push("pre_flush_x4", 0, 1, 64'h0, 1'b1);
        end
        4: begin
          rd_addr = {5'd4, 5'd2};
          push("flush_x2", 0, 0, 64'h0, 1'b0);
          push("flush_claim_x4", 0, 1, 64'h0, 1'b1);
          push("flush_x2_nb", 1, 0, 64'h0, 1'b0);
        end
        5: begin
          flush = 1'b1;
          rd_addr = {5'd4, 5'd9};
          push("flush_x9", 0, 0, 64'h55, 1'b0);
          push("pre_flush2_x4", 0, 1, 64'h0, 1'b1);
        end
        default: begin
          rd_addr = {5'd4, 5'd9};
          push("flush2_x4", 0, 1, 64'h0, 1'b0);
          push("flush2_x4_nb", 1, 1, 64'h0, 1'b0);
        end
      endcase
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = act(e.dut, e.port);
        n_checks++;
        if (a[63:0] !== e.data || a[64] !== e.busy) begin
          n_errors++;
          $display("FAIL %s cyc%0d dut%0d port%0d: got data=%h busy=%b, expected data=%h busy=%b",
                   e.name, c, e.dut, e.port, a[63:0], a[64], e.data, e.busy);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [64:0] a;
    logic [31:0] cur, prev;
    prev = 32'h55;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      clr_strobes();
      if (c < 4) begin
        cur = 32'h1000_0000 + 32'(c) * 32'h1111;
        wr_en = 1'b1; wr_addr = 5'(10 + c); wr_data = cur;
        rd_addr = {5'(9 + c), 5'(10 + c)};
        push("b2b_bypass", 0, 0, {32'h0, cur}, 1'b0);
        push("b2b_nb_old", 1, 0, 64'h0, 1'b0);
        push("b2b_prev", 0, 1, {32'h0, prev}, 1'b0);
        push("b2b_prev_nb", 1, 1, {32'h0, prev}, 1'b0);
        prev = cur;
      end else begin
        rd_addr = {5'd12, 5'd13};
        push("b2b_last", 0, 0, {32'h0, prev}, 1'b0);
        push("b2b_last_nb", 1, 0, {32'h0, prev}, 1'b0);
        push("b2b_x12", 0, 1, 64'h1000_2222, 1'b0);
      end
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = act(e.dut, e.port);
        n_checks++;
        if (a[63:0] !== e.data || a[64] !== e.busy) begin
          n_errors++;
          $display("FAIL %s cyc%0d dut%0d port%0d: got data=%h busy=%b, expected data=%h busy=%b",
                   e.name, c, e.dut, e.port, a[63:0], a[64], e.data, e.busy);
        end
      end
    end
  endtask

  task automatic test_param();
    exp_t e;
    logic [64:0] a;
    logic [63:0] v15, v14, v1;
    v15 = 64'hFFFF_0000_FFFF_0000;
    v14 = 64'h1111_2222_3333_4444;
    v1  = 64'h0123_4567_89AB_CDEF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      clr_strobes();
      p_rd_addr = {4'd1, 4'd14, 4'd15};
      case (c)
        0: begin
          p_wr_en = 1'b1; p_wr_addr = 4'd15; p_wr_data = v15;
          push("p_x15_bypass", 2, 0, v15, 1'b0);
          push("p_x14_empty", 2, 1, 64'h0, 1'b0);
          push("p_x1_empty", 2, 2, 64'h0, 1'b0);
        end
        1: begin
          p_wr_en = 1'b1; p_wr_addr = 4'd14; p_wr_data = v14;
          push("p_x15", 2, 0, v15, 1'b0);
          push("p_x14_bypass", 2, 1, v14, 1'b0);
          push("p_x1_empty2", 2, 2, 64'h0, 1'b0);
        end
        2: begin
          p_wr_en = 1'b1; p_wr_addr = 4'd1; p_wr_data = v1;
          push("p_x1_bypass", 2, 2, v1, 1'b0);
        end
        3: begin
          p_claim_en = 1'b1; p_claim_addr = 4'd15;
          push("p_x15_state", 2, 0, v15, 1'b0);
          push("p_x14_state", 2, 1, v14, 1'b0);
          push("p_x1_state", 2, 2, v1, 1'b0);
        end
        4: begin
          p_rd_addr = {4'd15, 4'd15, 4'd15};
          for (int p = 0; p < 3; p++) push("p_same_reg", 2, p, v15, 1'b1);
        end
        default: begin
          p_rd_addr = {4'd0, 4'd14, 4'd15};
          push("p_x15_busy", 2, 0, v15, 1'b1);
          push("p_x14_idle", 2, 1, v14, 1'b0);
          push("p_x0", 2, 2, 64'h0, 1'b0);
        end
      endcase
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = act(e.dut, e.port);
        n_checks++;
        if (a[63:0] !== e.data || a[64] !== e.busy) begin
          n_errors++;
          $display("FAIL %s cyc%0d port%0d: got data=%h busy=%b, expected data=%h busy=%b",
                   e.name, c, e.port, a[63:0], a[64], e.data, e.busy);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; claim_addr = '0;
    p_rd_addr = '0; p_wr_addr = '0; p_wr_data = '0; p_claim_addr = '0;
    clr_strobes();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    test_reset();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_back_to_back();
    test_param();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
